// File: rtl/netlist_share_arbiter.sv
// netlist_share_arbiter: round-robin sharing of one combinational netlist among NUM_REQ requesters.
// Define NSA_SIGNATURE_EN to build the 16-bit response signature register on sig_out.
module netlist_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IN_W = 14,
    parameter int OUT_W = 8,
    parameter int SETTLE = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [IN_W-1:0]         core_in,
    input  logic [OUT_W-1:0]        core_out,
    output logic [15:0]             sig_out
);
    localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, RESP = 2'd2;
    logic [1:0] state_q;
    logic [ID_W-1:0] ptr_q, id_q, rsp_id_q, win;
    logic [ID_W:0] idx;
    logic [3:0] cnt_q;
    logic [IN_W-1:0] core_in_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic rsp_valid_q, found, xfer;
    logic [IN_W-1:0] ops [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign ops[g] = req_data[g*IN_W +: IN_W];
    end

    // Scan from ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win = idx[ID_W-1:0];
            end
        end
    end

    assign req_ready = (state_q == IDLE && found && !rst) ? NUM_REQ'(1) << win : '0;
    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            id_q <= '0;
            cnt_q <= '0;
            core_in_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (xfer) begin
                    core_in_q <= ops[win];
                    id_q <= win;
                    cnt_q <= 4'(SETTLE - 1);
                    state_q <= EVAL;
                end
                EVAL: if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    rsp_data_q <= core_out;
                    rsp_id_q <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_in = core_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_data = rsp_data_q;

`ifdef NSA_SIGNATURE_EN
    logic [15:0] sig_q;
    logic hs;
    assign hs = rsp_valid_q & rsp_ready;
    // CRC-16/CCITT-style shift folded with {id, data} of each accepted response.
    always_ff @(posedge clk) begin
        if (rst) sig_q <= '0;
        else if (hs) sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {8'(rsp_id_q), 8'(rsp_data_q)};
    end
    assign sig_out = sig_q;
`else
    assign sig_out = 16'h0000;
`endif
endmodule

// File: tb/tb_netlist_share_arbiter.sv
// tb_netlist_share_arbiter: directed and randomized checks of netlist_share_arbiter against a transaction-level model.
module tb_netlist_share_arbiter;
    localparam int NUM_REQ = 4, IN_W = 14, OUT_W = 8, SETTLE = 2;
`ifdef NSA_SIGNATURE_EN
    localparam logic [15:0] SIG1 = 16'h003C, SIG2 = 16'h01F9;
`else
    localparam logic [15:0] SIG1 = 16'h0000, SIG2 = 16'h0000;
`endif
    logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b0, rsp_valid;
    logic [3:0] req_valid = '0, req_ready;
    logic [55:0] req_data = '0;
    logic [1:0] rsp_id;
    logic [7:0] rsp_data, core_out;
    logic [13:0] core_in;
    logic [15:0] sig_out;
    logic force_en = 1'b0;
    logic [7:0] force_val = '0;
    int n_checks = 0, n_fail = 0;

    bit m_busy = 0;
    int m_age = 0, m_id = 0, m_ptr = 0;
    logic [13:0] m_op = '0;
    logic [1:0] m_rid = '0;
    logic [7:0] m_rdata = '0;
    logic [15:0] m_sig = '0;

    netlist_share_arbiter #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .core_in(core_in), .core_out(core_out), .sig_out(sig_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] core_fn(input logic [13:0] x);
        return (x[7:0] + {2'b00, x[13:8]}) ^ {x[3:0], x[13:10]};
    endfunction

    assign core_out = force_en ? force_val : core_fn(core_in);

    function automatic int winner();
        for (int k = 0; k < NUM_REQ; k++)
            if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w = winner();
        return (rst || m_busy || w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    function automatic logic [15:0] exp_sig();
`ifdef NSA_SIGNATURE_EN
        return m_sig;
`else
        return 16'h0000;
`endif
    endfunction

    // Advance the transaction model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int w;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_op = '0; m_rid = '0; m_rdata = '0; m_sig = '0;
        end else if (!m_busy) begin
            w = winner();
            if (w >= 0) begin
                m_busy = 1; m_age = 1; m_id = w; m_op = req_data[w*IN_W +: IN_W];
            end
        end else begin
            if (m_age == SETTLE) begin
                m_rid = 2'(m_id);
                m_rdata = force_en ? force_val : core_fn(m_op);
            end
            if (m_age > SETTLE && rsp_ready) begin
                m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {6'b0, m_rid, m_rdata};
                m_busy = 0;
                m_ptr = (m_id + 1) % NUM_REQ;
            end
            m_age++;
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0; rsp_ready = 1'b1;
        repeat (SETTLE + 3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = {$urandom, $urandom}; rsp_ready = 1'b1;
        step(); step();
        #1;
        n_checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || core_in !== 14'h0 || rsp_id !== 2'd0 || rsp_data !== 8'h0 || sig_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%b rv=%b core_in=%h id=%0d data=%h sig=%h, required all zero", req_ready, rsp_valid, core_in, rsp_id, rsp_data, sig_out);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_data = '0; req_data[2*IN_W +: IN_W] = 14'h1A5; rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 0) begin
                n_checks++;
                if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: req_ready=%b required 0100", req_ready); end
            end else begin
                n_checks++;
                if (core_in !== 14'h1A5) begin n_fail++; $display("FAIL single_core_in k=%0d: core_in=%h required 1a5", k, core_in); end
                n_checks++;
                if (rsp_valid !== (k == 3)) begin n_fail++; $display("FAIL single_rsp_valid k=%0d: rsp_valid=%b required %b", k, rsp_valid, k == 3); end
            end
            if (k == 3) begin
                n_checks++;
                if (rsp_id !== 2'd2 || rsp_data !== core_fn(14'h1A5))
                    begin n_fail++; $display("FAIL single_rsp: id=%0d data=%h required id=2 data=%h", rsp_id, rsp_data, core_fn(14'h1A5)); end
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] er;
        rst = 1'b1; step(); rst = 1'b0;
        req_valid = 4'hF; req_data = {$urandom, $urandom}; rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            er = (k % 4 == 0) ? 4'(1 << ((k / 4) % 4)) : 4'b0000;
            n_checks++;
            if (req_ready !== er) begin n_fail++; $display("FAIL rr_grant k=%0d: req_ready=%b required %b", k, req_ready, er); end
            n_checks++;
            if (rsp_valid !== (k % 4 == 3)) begin n_fail++; $display("FAIL rr_rsp_valid k=%0d: rsp_valid=%b required %b", k, rsp_valid, k % 4 == 3); end
            if (k % 4 == 3) begin
                n_checks++;
                if (rsp_id !== 2'((k / 4) % 4)) begin n_fail++; $display("FAIL rr_rsp_id k=%0d: rsp_id=%0d required %0d", k, rsp_id, (k / 4) % 4); end
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        int t = 0;
        logic [1:0] id0;
        logic [7:0] d0;
        drain();
        rsp_ready = 1'b0; req_valid = 4'($urandom_range(1, 15)); req_data = {$urandom, $urandom};
        #1;
        while (rsp_valid !== 1'b1 && t < 20) begin
            step(); req_valid = 4'($urandom_range(1, 15)); #1; t++;
        end
        n_checks++;
        if (t == 20) begin n_fail++; $display("FAIL bp_timeout: rsp_valid=%b required 1 within 20 cycles", rsp_valid); end
        id0 = rsp_id; d0 = rsp_data;
        n_checks++;
        if (id0 !== m_rid || d0 !== m_rdata) begin n_fail++; $display("FAIL bp_rsp: id=%0d data=%h required id=%0d data=%h", id0, d0, m_rid, m_rdata); end
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_data !== d0 || req_ready !== 4'b0)
                begin n_fail++; $display("FAIL bp_hold j=%0d: rv=%b id=%0d data=%h ready=%b required 1/%0d/%h/0000", j, rsp_valid, rsp_id, rsp_data, req_ready, id0, d0); end
            step(); req_valid = 4'($urandom_range(1, 15)); req_data = {$urandom, $urandom}; #1;
        end
        rsp_ready = 1'b1;
        step(); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== exp_ready() || req_ready === 4'b0)
            begin n_fail++; $display("FAIL bp_release: rv=%b ready=%b required rv=0 ready=%b", rsp_valid, req_ready, exp_ready()); end
        step(); #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_hs: rsp_valid=%b required 0", rsp_valid); end
        drain();
    endtask

    task automatic test_reset_eval();
        drain();
        req_valid = 4'b0001; #1; step();
        req_valid = 4'b0000; repeat (SETTLE + 2) step();
        req_valid = 4'b1000; req_data = {$urandom, $urandom}; #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL re_grant3: req_ready=%b required 1000", req_ready); end
        step();
        rst = 1'b1; req_valid = 4'b1001; #1;
        n_checks++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL re_ready_in_reset: req_ready=%b required 0000", req_ready); end
        step();
        rst = 1'b0; #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || core_in !== 14'h0 || req_ready !== 4'b0001)
            begin n_fail++; $display("FAIL re_after: rv=%b core_in=%h ready=%b required 0/0000/0001", rsp_valid, core_in, req_ready); end
        step();
        req_valid = 4'b0000; repeat (SETTLE) step(); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL re_rsp: rv=%b id=%0d required 1/0", rsp_valid, rsp_id); end
        drain();
    endtask

    task automatic test_operand_change();
        drain();
        req_data[1*IN_W +: IN_W] = 14'h0123; req_valid = 4'b0010; #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL oc_grant: req_ready=%b required 0010", req_ready); end
        step();
        req_data[1*IN_W +: IN_W] = 14'h3ABC; req_valid = 4'b0000;
        repeat (SETTLE) step(); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== core_fn(14'h0123) || core_in !== 14'h0123)
            begin n_fail++; $display("FAIL oc_rsp: rv=%b data=%h core_in=%h required 1/%h/0123", rsp_valid, rsp_data, core_in, core_fn(14'h0123)); end
        drain();
    endtask

    task automatic test_signature();
        rst = 1'b1; step(); rst = 1'b0;
        force_en = 1'b1; force_val = 8'h3C; rsp_ready = 1'b1; req_valid = 4'b0001; #1; step();
        req_valid = 4'b0000; repeat (SETTLE + 1) step(); #1;
        n_checks++;
        if (sig_out !== SIG1) begin n_fail++; $display("FAIL sig_first: sig_out=%h required %h", sig_out, SIG1); end
        force_val = 8'h81; req_valid = 4'b0010; #1; step();
        req_valid = 4'b0000; repeat (SETTLE + 1) step(); #1;
        n_checks++;
        if (sig_out !== SIG2 || rsp_id !== 2'd1 || rsp_data !== 8'h81)
            begin n_fail++; $display("FAIL sig_second: sig_out=%h id=%0d data=%h required %h/1/81", sig_out, rsp_id, rsp_data, SIG2); end
        force_en = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            req_data = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if (req_ready !== exp_ready() || rsp_valid !== (m_busy && m_age > SETTLE) || rsp_id !== m_rid ||
                rsp_data !== m_rdata || core_in !== m_op || sig_out !== exp_sig()) begin
                n_fail++;
                $display("FAIL random c=%0d: ready=%b rv=%b id=%0d data=%h core_in=%h sig=%h required %b/%b/%0d/%h/%h/%h", c,
                         req_ready, rsp_valid, rsp_id, rsp_data, core_in, sig_out,
                         exp_ready(), m_busy && m_age > SETTLE, m_rid, m_rdata, m_op, exp_sig());
            end
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_reset_eval();
        test_operand_change();
        test_signature();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
